esu_sched: RTL and testbench

Round-robin scheduler that shares one `esu` (edge scheduling unit: `t_off = t_up/|velocity| - t_on`, `dir = sign(velocity)`) among `NUM_AXES` axis requesters. It sits between the per-axis step generators and the single ESU instance. For each request it:
- arbitrates;
- latches operands;
- issues a one-cycle start;
- waits for the ESU done pulse, with a watchdog;
- returns `t_off`/`dir` to the granted axis.

Zero velocity is resolved locally, without using the ESU.

---
 rtl/esu_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/esu_sched.sv | 148 ++++++++++++++
 tb/tb_esu_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esu_pkg.sv
// Shared definitions for the ESU round-robin scheduler.
package esu_pkg;

   // Scheduler sequence: grant/latch, start pulse, wait for ESU, strobe result.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } esu_state_e;

   // Off time reported for a stationary axis: the next edge never comes.
   localparam logic [31:0] T_OFF_NEVER = 32'hFFFF_FFFF;

   // Default watchdog limit, in WAIT cycles.
   localparam int unsigned DEFAULT_TIMEOUT = 64;

   // Successor of a requester index, wrapping modulo n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int unsigned   cand;
   logic [IW-1:0] cand_idx;

   // Scan N positions starting at ptr; the first asserted request wins.
   always_comb begin
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = {{(32-IW){1'b0}}, ptr} + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IW'(cand);
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            idx           = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/esu_sched.sv
// Shares one edge scheduling unit among NUM_AXES requesters, round-robin,
// with a watchdog on the ESU and a local shortcut for zero velocity.
module esu_sched
   import esu_pkg::*;
#(
   parameter int unsigned NUM_AXES = 4,
   parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     N_reset,
   input  logic [NUM_AXES-1:0]      req,
   input  logic [NUM_AXES-1:0][31:0] velocity,
   input  logic [NUM_AXES-1:0][31:0] t_on,
   input  logic [31:0]              t_up,
   output logic [NUM_AXES-1:0]      ack,
   output logic [31:0]              res_t_off,
   output logic                     res_dir,
   output logic                     res_err,
   output logic                     esu_start,
   output logic [31:0]              esu_t_up,
   output logic [31:0]              esu_t_on,
   output logic [31:0]              esu_velocity,
   input  logic [31:0]              esu_t_off,
   input  logic                     esu_dir,
   input  logic                     esu_done
);

   localparam int unsigned IW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

   esu_state_e          state_q;
   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       ptr_d;
   logic [NUM_AXES-1:0] gnt_q;
   logic [WW-1:0]       wdog_q;
   logic [NUM_AXES-1:0] ack_q;
   logic [31:0]         res_t_off_q;
   logic                res_dir_q;
   logic                res_err_q;
   logic                start_q;
   logic [31:0]         op_t_up_q;
   logic [31:0]         op_t_on_q;
   logic [31:0]         op_vel_q;

   logic [NUM_AXES-1:0] arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;
   logic [31:0]         sel_vel;
   logic [31:0]         sel_t_on;

   rr_arbiter #(
      .N (NUM_AXES)
   ) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Operand mux for the winning axis and the pointer value after this grant.
   always_comb begin
      sel_vel  = velocity[arb_idx];
      sel_t_on = t_on[arb_idx];
      ptr_d    = IW'(rr_next(32'(arb_idx), NUM_AXES));
   end

   // Scheduler FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge N_reset) begin
      if (!N_reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         wdog_q      <= '0;
         ack_q       <= '0;
         res_t_off_q <= '0;
         res_dir_q   <= 1'b0;
         res_err_q   <= 1'b0;
         start_q     <= 1'b0;
         op_t_up_q   <= '0;
         op_t_on_q   <= '0;
         op_vel_q    <= '0;
      end else begin
         start_q <= 1'b0;
         ack_q   <= '0;
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  gnt_q     <= arb_gnt;
                  ptr_q     <= ptr_d;
                  op_t_up_q <= t_up;
                  op_t_on_q <= sel_t_on;
                  op_vel_q  <= sel_vel;
                  if (sel_vel == '0) begin
                     // Stationary axis: answer locally, ack lands in RESULT.
                     res_t_off_q <= T_OFF_NEVER;
                     res_dir_q   <= 1'b0;
                     res_err_q   <= 1'b0;
                     ack_q       <= arb_gnt;
                     state_q     <= RESULT;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               wdog_q  <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (esu_done) begin
                  res_t_off_q <= esu_t_off;
                  res_dir_q   <= esu_dir;
                  res_err_q   <= 1'b0;
                  ack_q       <= gnt_q;
                  state_q     <= RESULT;
               end else if (wdog_q == WDOG_LAST) begin
                  res_t_off_q <= '0;
                  res_dir_q   <= 1'b0;
                  res_err_q   <= 1'b1;
                  ack_q       <= gnt_q;
                  state_q     <= RESULT;
               end else begin
                  wdog_q <= wdog_q + WW'(1);
               end
            end
            RESULT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack          = ack_q;
   assign res_t_off    = res_t_off_q;
   assign res_dir      = res_dir_q;
   assign res_err      = res_err_q;
   assign esu_start    = start_q;
   assign esu_t_up     = op_t_up_q;
   assign esu_t_on     = op_t_on_q;
   assign esu_velocity = op_vel_q;

endmodule

// File: tb/tb_esu_sched.sv
// Bench for esu_sched: behavioural ESU stub, transaction-level expectation
// model, per-cycle comparison and directed scenarios.
module tb_esu_sched;

   localparam int NA  = 4;
   localparam int TMO = 8;

   logic             clk = 1'b0;
   logic             N_reset = 1'b0;
   logic [3:0]       req = '0;
   logic [3:0][31:0] velocity = '0;
   logic [3:0][31:0] t_on = '0;
   logic [31:0]      t_up = 32'd1000;
   logic [3:0]       ack;
   logic [31:0]      res_t_off;
   logic             res_dir, res_err, esu_start;
   logic [31:0]      esu_t_up, esu_t_on, esu_velocity;
   logic [31:0]      stub_toff = '0;
   logic             stub_dir = 1'b0, stub_done = 1'b0, stray_done = 1'b0;
   logic             esu_done;

   int esu_lat = 3;
   bit esu_hang = 1'b0;
   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int starts = 0, last_start_cyc = 0;
   int order [6] = '{0, 1, 2, 3, 0, 1};

   assign esu_done = stub_done | stray_done;

   esu_sched #(
      .NUM_AXES (NA),
      .TIMEOUT  (TMO)
   ) dut (
      .clk          (clk),
      .N_reset      (N_reset),
      .req          (req),
      .velocity     (velocity),
      .t_on         (t_on),
      .t_up         (t_up),
      .ack          (ack),
      .res_t_off    (res_t_off),
      .res_dir      (res_dir),
      .res_err      (res_err),
      .esu_start    (esu_start),
      .esu_t_up     (esu_t_up),
      .esu_t_on     (esu_t_on),
      .esu_velocity (esu_velocity),
      .esu_t_off    (stub_toff),
      .esu_dir      (stub_dir),
      .esu_done     (esu_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // t_off = t_up / |v| - t_on
   function automatic logic [31:0] esu_calc(input logic [31:0] tu, input logic [31:0] v,
                                            input logic [31:0] ton);
      longint sv, mag;
      sv  = longint'($signed(v));
      mag = (sv < 0) ? -sv : sv;
      return 32'(longint'(tu) / mag - longint'(ton));
   endfunction

   // ESU stub: done pulse esu_lat cycles after start, or never when hung.
   int rem = 0;
   always @(posedge clk or negedge N_reset) begin
      if (!N_reset) begin
         rem = 0;
         stub_done <= 1'b0;
         stub_toff <= '0;
         stub_dir  <= 1'b0;
      end else begin
         stub_done <= 1'b0;
         if (esu_start && !esu_hang) begin
            rem = esu_lat;
            stub_toff <= esu_calc(esu_t_up, esu_velocity, esu_t_on);
            stub_dir  <= esu_velocity[31];
         end
         if (rem > 0) begin
            rem--;
            if (rem == 0) stub_done <= 1'b1;
         end
      end
   end

   // Expectation model: schedules per-transaction events by cycle number.
   logic [3:0]  exp_ack  [int];
   logic [31:0] exp_toff [int];
   logic        exp_dir  [int];
   logic        exp_err  [int];
   bit          exp_start[int];
   logic [31:0] op_tup   [int];
   logic [31:0] op_ton   [int];
   logic [31:0] op_vel   [int];
   int m_ptr = 0, m_free = 0;

   always @(posedge clk or negedge N_reset) begin : model
      int g, lat, c, p;
      logic [31:0] tf;
      logic        d, e;
      if (!N_reset) begin
         exp_ack.delete(); exp_toff.delete(); exp_dir.delete(); exp_err.delete();
         exp_start.delete(); op_tup.delete(); op_ton.delete(); op_vel.delete();
         m_ptr  = 0;
         m_free = 0;
      end else begin
         c = cyc;
         if (c >= m_free && req != 4'b0) begin
            g = -1;
            for (int k = 0; k < NA; k++) begin
               p = (m_ptr + k) % NA;
               if (g < 0 && req[p]) g = p;
            end
            m_ptr = (g + 1) % NA;
            op_tup[c+1] = t_up;
            op_ton[c+1] = t_on[g];
            op_vel[c+1] = velocity[g];
            if (velocity[g] == 32'd0) begin
               lat = 1; tf = 32'hFFFF_FFFF; d = 1'b0; e = 1'b0;
            end else begin
               exp_start[c+1] = 1'b1;
               if (esu_hang) begin
                  lat = TMO + 2; tf = 32'd0; d = 1'b0; e = 1'b1;
               end else begin
                  lat = esu_lat + 2;
                  tf  = esu_calc(t_up, velocity[g], t_on[g]);
                  d   = velocity[g][31];
                  e   = 1'b0;
               end
            end
            exp_ack[c+lat]  = 4'(1 << g);
            exp_toff[c+lat] = tf;
            exp_dir[c+lat]  = d;
            exp_err[c+lat]  = e;
            m_free = c + lat + 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [31:0] h_toff = '0, h_tup = '0, h_ton = '0, h_vel = '0;
   logic        h_dir = 1'b0, h_err = 1'b0;
   always @(negedge clk) begin : compare
      logic [3:0] ea;
      logic       es;
      if (!N_reset) begin
         h_toff = '0; h_tup = '0; h_ton = '0; h_vel = '0; h_dir = 1'b0; h_err = 1'b0;
         check("reset_outputs_zero",
               32'({ack, res_dir, res_err, esu_start}) | res_t_off | esu_t_up | esu_t_on | esu_velocity,
               32'd0);
      end else begin
         ea = exp_ack.exists(cyc) ? exp_ack[cyc] : 4'b0;
         es = exp_start.exists(cyc);
         if (ea != 4'b0) begin
            h_toff = exp_toff[cyc];
            h_dir  = exp_dir[cyc];
            h_err  = exp_err[cyc];
         end
         if (op_vel.exists(cyc)) begin
            h_tup = op_tup[cyc];
            h_ton = op_ton[cyc];
            h_vel = op_vel[cyc];
         end
         check("ack", 32'(ack), 32'(ea));
         check("esu_start", 32'(esu_start), 32'(es));
         check("res_t_off", res_t_off, h_toff);
         check("res_dir", 32'(res_dir), 32'(h_dir));
         check("res_err", 32'(res_err), 32'(h_err));
         check("esu_t_up", esu_t_up, h_tup);
         check("esu_t_on", esu_t_on, h_ton);
         check("esu_velocity", esu_velocity, h_vel);
      end
   end

   // Start-pulse monitor.
   always @(negedge clk) begin
      if (esu_start) begin
         starts++;
         last_start_cyc = cyc;
      end
   end

   task automatic wait_ack(input int maxc, output logic [3:0] a, output int lat);
      a   = '0;
      lat = 0;
      while (lat < maxc) begin
         @(negedge clk);
         lat++;
         if (ack != 4'b0) begin
            a = ack;
            break;
         end
      end
      check("ack_seen", 32'(a != 4'b0), 32'd1);
   endtask

   initial begin : stim
      logic [3:0] a;
      int lat, s0;

      repeat (3) @(negedge clk);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_start", 32'(esu_start), 32'd0);
      #1 N_reset = 1'b1;

      // single request, axis 1: 1000/10 - 30 = 70
      @(negedge clk);
      velocity[1] = 32'd10; t_on[1] = 32'd30; req = 4'b0010;
      wait_ack(40, a, lat);
      check("single_ack", 32'(a), 32'h2);
      check("single_toff", res_t_off, 32'd70);
      check("single_dir", 32'(res_dir), 32'd0);
      check("single_lat", 32'(lat), 32'd5);
      req = 4'b0;

      // negative velocity, axis 2: 1000/8 - 25 = 100
      @(negedge clk);
      velocity[2] = 32'hFFFF_FFF8; t_on[2] = 32'd25; req = 4'b0100;
      wait_ack(40, a, lat);
      check("neg_ack", 32'(a), 32'h4);
      check("neg_toff", res_t_off, 32'd100);
      check("neg_dir", 32'(res_dir), 32'd1);
      req = 4'b0;

      // zero velocity, axis 3
      @(negedge clk);
      s0 = starts;
      velocity[3] = 32'd0; t_on[3] = 32'd10; req = 4'b1000;
      wait_ack(40, a, lat);
      check("zero_ack", 32'(a), 32'h8);
      check("zero_toff", res_t_off, 32'hFFFF_FFFF);
      check("zero_lat", 32'(lat), 32'd1);
      check("zero_no_start", 32'(starts), 32'(s0));
      req = 4'b0;

      // fairness with all requests held
      @(negedge clk);
      velocity[0] = 32'd5; t_on[0] = 32'd30; velocity[3] = 32'd20; req = 4'hF;
      for (int i = 0; i < 6; i++) begin
         wait_ack(40, a, lat);
         check("fair_order", 32'(a), 32'(1 << order[i]));
      end
      req = 4'b0;

      // stray done while idle
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_no_ack", 32'(ack), 32'd0);
      check("stray_hold", res_t_off, 32'd70);

      // withdrawal before grant, deassertion after grant
      @(negedge clk);
      req = 4'b1000;
      @(negedge clk);
      req = 4'b1011;
      repeat (2) @(negedge clk);
      req = 4'b1010;
      wait_ack(40, a, lat);
      check("wd_first", 32'(a), 32'h8);
      check("wd_first_toff", res_t_off, 32'd40);
      req = 4'b0010;
      repeat (2) @(negedge clk);
      req = 4'b0;
      wait_ack(40, a, lat);
      check("wd_skip0", 32'(a), 32'h2);

      // watchdog: ESU never answers
      @(negedge clk);
      esu_hang = 1'b1; velocity[0] = 32'd7; req = 4'b0001;
      wait_ack(40, a, lat);
      check("wdog_ack", 32'(a), 32'h1);
      check("wdog_err", 32'(res_err), 32'd1);
      check("wdog_toff", res_t_off, 32'd0);
      check("wdog_lat", 32'(lat), 32'd10);
      check("wdog_start_to_ack", 32'(cyc - last_start_cyc), 32'd9);
      req = 4'b0;
      esu_hang = 1'b0;

      // next request served normally: 1000/7 - 30 = 112
      @(negedge clk);
      req = 4'b0001;
      wait_ack(40, a, lat);
      check("post_wdog_ack", 32'(a), 32'h1);
      check("post_wdog_err", 32'(res_err), 32'd0);
      check("post_wdog_toff", res_t_off, 32'd112);
      req = 4'b0;

      // reset in the middle of WAIT
      @(negedge clk);
      req = 4'b0100;
      repeat (3) @(negedge clk);
      #1 N_reset = 1'b0;
      #1;
      check("rst_mid_ack", 32'(ack), 32'd0);
      check("rst_mid_vel", esu_velocity, 32'd0);
      check("rst_mid_toff", res_t_off, 32'd0);
      check("rst_mid_start", 32'(esu_start), 32'd0);
      req = 4'b1001;
      repeat (2) @(negedge clk);
      #1 N_reset = 1'b1;
      wait_ack(40, a, lat);
      check("rst_first_grant", 32'(a), 32'h1);
      req = 4'b1000;
      wait_ack(40, a, lat);
      check("rst_second_grant", 32'(a), 32'h8);
      check("rst_second_toff", res_t_off, 32'd40);
      req = 4'b0;

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : guard
      #100000;
      $display("FAIL global_timeout: simulation still running, required to finish");
      $fatal(1, "bench time limit exceeded");
   end

endmodule
